interval_timer: RTL
===================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - VAL_W, 4, width of the time value and of the count.
  - INVALID_VAL, 15, value returned by the time-parameter store for the unmapped selector 2'b11.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clock, in, 1, single clock; all state changes on its rising edge.
  - reset_n, in, 1, asynchronous active-low reset.
  - start, in, 1, one-cycle pulse requesting a timed interval.
  - interval_sel, in, 2, interval ID: 00 base, 01 extended, 10 yellow, 11 invalid; sampled with start.
  - abort, in, 1, cancels any interval in progress.
  - tick, in, 1, one-cycle time-base enable; one tick is one time unit.
  - prog_sync, in, 1, the time-parameter store is being programmed, so value is frozen.
  - value, in, VAL_W, registered value returned by the time-parameter store.
  - interval, out, 2, selector driven to the time-parameter store.
  - busy, out, 1, high in every state except IDLE.
  - expired, out, 1, one-cycle pulse at interval end.
  - error, out, 1, one-cycle pulse when an invalid interval is rejected.
  - remaining, out, VAL_W, current count.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT, COUNT and DONE, held in a registered state variable.
REQ-004 In IDLE, start=1 SHALL latch interval_sel into interval and move to REQ; start in any other state SHALL be ignored.
REQ-005 REQ SHALL last exactly one cycle, holding interval stable so the store registers value at that edge, then move to WAIT.
REQ-006 In WAIT with prog_sync=0, the block SHALL capture value into the count and move to COUNT; with prog_sync=1 it SHALL stay in WAIT.
REQ-007 If the captured value equals INVALID_VAL and interval is 2'b11, the block SHALL pulse error for one cycle, load no count, and return to IDLE.
REQ-008 If the captured value is 0, the block SHALL move directly to DONE without waiting for a tick.
REQ-009 In COUNT, each tick=1 SHALL decrement the count; a tick while the count is 1 SHALL move to DONE, leaving remaining at 0.
REQ-010 Ticks arriving in IDLE, REQ or WAIT SHALL be ignored and SHALL NOT be stored.
REQ-011 DONE SHALL assert expired for exactly one cycle and then return to IDLE; the earliest accepted restart is start in that following IDLE cycle.
REQ-012 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no expired or error pulse, and SHALL clear remaining to 0.
REQ-013 If abort and tick are both high in the cycle where the count is 1, abort SHALL win and expired SHALL NOT pulse.
REQ-014 remaining SHALL equal the registered count, be 0 in IDLE, and never wrap below 0.
REQ-015 The latency from start to the first count decrement SHALL be at least 3 cycles: REQ, WAIT, then COUNT.

Reset
REQ-016 While reset_n=0, the block SHALL force state=IDLE, interval=2'b00, count=0, and busy, expired and error to 0, independent of clock.
REQ-017 Deassertion of reset_n mid-interval SHALL resume from IDLE only; no interval SHALL be in progress after reset.

Configuration
REQ-018 Macro TIMER_EXTEND_EN defined:
  - Adds the input port extend (1 bit).
  - extend=1 in COUNT SHALL drive interval=2'b01 for one cycle, wait one cycle, then add value to the count, saturating at 2^VAL_W-1.
  - Ticks SHALL continue to decrement the count during the fetch; a tick and the add in the same cycle SHALL apply the add then the decrement.
  - After the add, interval SHALL be restored to the originally latched selector.
REQ-019 Macro TIMER_EXTEND_EN undefined: there SHALL be no extend port and no extension logic.

Verification
REQ-020 Start with interval_sel=00 and value=6, ticks every 4 cycles -> interval=00 one cycle after start; remaining loads 6 and counts 6..1; one expired pulse on the 6th tick; busy falls with it.
REQ-021 Start with interval_sel=11 and value=15 -> error pulses once, expired never pulses, back in IDLE 3 cycles after start.
REQ-022 prog_sync held high 5 cycles during WAIT with value=2 -> the FSM stays in WAIT for those 5 cycles, then loads 2 and expires after 2 ticks.
REQ-023 abort asserted together with the final tick at remaining=1 -> no expired pulse, remaining=0, IDLE next cycle.
REQ-024 reset_n pulsed low mid-COUNT at remaining=4 -> all outputs go to 0 asynchronously; a new start then runs normally.
REQ-025 With TIMER_EXTEND_EN defined, extend at remaining=3 with extended value=3 and no ticks -> remaining becomes 6; the bench SHALL also check that base value 14 with extended value 3 saturates to 15.

Source files
------------

// File: rtl/interval_timer.sv
// Interval timer: fetches a duration from a time-parameter store and counts it down.
// Optional TIMER_EXTEND_EN adds an extend input that fetches and adds the extended value.
module interval_timer #(
  parameter int VAL_W       = 4,
  parameter int INVALID_VAL = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       interval_sel,
  input  logic             abort,
  input  logic             tick,
  input  logic             prog_sync,
  input  logic [VAL_W-1:0] value,
`ifdef TIMER_EXTEND_EN
  input  logic             extend,
`endif
  output logic [1:0]       interval,
  output logic             busy,
  output logic             expired,
  output logic             error,
  output logic [VAL_W-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COUNT,
    DONE
  } state_t;

  localparam logic [VAL_W-1:0] ONE = VAL_W'(1);
  localparam logic [VAL_W-1:0] INV = VAL_W'(INVALID_VAL);

  state_t           state_q;
  state_t           state_d;
  logic [VAL_W-1:0] cnt_q;
  logic [VAL_W-1:0] cnt_d;
  logic [VAL_W-1:0] base;
  logic [1:0]       sel_q;
  logic             err_q;
  logic             err_d;
  logic             invalid;
  logic             kill;

  assign kill    = abort && (state_q != IDLE);
  assign invalid = (value == INV) && (sel_q == 2'b11);

`ifdef TIMER_EXTEND_EN
  typedef enum logic [1:0] {
    EXT_OFF,
    EXT_REQ,
    EXT_WAIT
  } ext_t;

  ext_t           ext_q;
  logic           ext_add;
  logic [VAL_W:0] sum_w;

  assign ext_add = (state_q == COUNT) &&
                   (ext_q == EXT_WAIT) &&
                   !prog_sync;
  assign sum_w   = {1'b0, cnt_q} + {1'b0, value};

  // Add lands before any same-cycle tick decrement
  always_comb begin
    base = cnt_q;
    if (ext_add) begin
      base = sum_w[VAL_W] ? '1 : sum_w[VAL_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= EXT_OFF;
    end else if (state_d != COUNT) begin
      ext_q <= EXT_OFF;
    end else begin
      unique case (ext_q)
        EXT_OFF:
          if (extend && state_q == COUNT)
            ext_q <= EXT_REQ;
        EXT_REQ:
          ext_q <= EXT_WAIT;
        EXT_WAIT:
          if (!prog_sync)
            ext_q <= EXT_OFF;
        default:
          ext_q <= EXT_OFF;
      endcase
    end
  end

  assign interval = (ext_q != EXT_OFF) ? 2'b01 : sel_q;
`else
  assign base     = cnt_q;
  assign interval = sel_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (start)
            state_d = REQ;
        REQ:
          state_d = WAIT;
        WAIT:
          if (!prog_sync) begin
            if (invalid)
              state_d = IDLE;
            else if (value == '0)
              state_d = DONE;
            else
              state_d = COUNT;
          end
        COUNT:
          if (tick && base == ONE)
            state_d = DONE;
        DONE:
          state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    expired = (state_q == DONE);
    error   = err_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      kill:
        cnt_d = '0;
      !abort && state_q == WAIT:
        if (!prog_sync && !invalid)
          cnt_d = value;
      !abort && state_q == COUNT:
        cnt_d = tick ? base - ONE : base;
      default:
        cnt_d = cnt_q;
    endcase
  end

  assign err_d = !abort &&
                 (state_q == WAIT) &&
                 !prog_sync &&
                 invalid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sel_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (state_q == IDLE && start)
        sel_q <= interval_sel;
    end
  end

  assign remaining = cnt_q;

endmodule
